// File: rtl/dram_arb_pkg.sv
//==============================================================================
// Module   : dram_arb_pkg
// Brief    : Shared types and constants for the two-port DRAM arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package dram_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : dram_arb_pkg

`default_nettype wire

// File: rtl/dram_arb_pick.sv
//==============================================================================
// Module   : dram_arb_pick
// Brief    : Combinational winner selection between the two request ports.
// Config   : DRAM_ARB_RR_EN - contended requests alternate against last_winner;
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  logic                 last_winner,
    output logic                 winner
);

`ifdef DRAM_ARB_RR_EN
    always_comb begin
        winner = 1'b0;
        if (&valid) begin
            winner = ~last_winner;
        end else begin
            winner = valid[1] & ~valid[0];
        end
    end
`else
    // Fixed priority ignores history; the input stays for a uniform interface.
    logic w_unused_last_winner;
    assign w_unused_last_winner = last_winner;

    always_comb begin
        winner = valid[1] & ~valid[0];
    end
`endif

endmodule : dram_arb_pick

`default_nettype wire

// File: rtl/dram_arbiter.sv
//==============================================================================
// Module   : dram_arbiter
// Brief    : Two-port arbiter (core LSU / DMA-debug) onto a single DRAM port,
//            with locked multi-beat sequences and registered read responses.
// Config   : DRAM_ARB_RR_EN - round-robin on contention (default: port 0 wins).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            p0_req_valid,
    output logic            p0_req_ready,
    input  logic            p0_req_we,
    input  logic [DW/8-1:0] p0_req_be,
    input  logic [AW-1:0]   p0_req_addr,
    input  logic [DW-1:0]   p0_req_wdat,
    input  logic            p0_req_last,
    output logic            p0_rsp_valid,
    output logic [DW-1:0]   p0_rsp_rdat,

    input  logic            p1_req_valid,
    output logic            p1_req_ready,
    input  logic            p1_req_we,
    input  logic [DW/8-1:0] p1_req_be,
    input  logic [AW-1:0]   p1_req_addr,
    input  logic [DW-1:0]   p1_req_wdat,
    input  logic            p1_req_last,
    output logic            p1_rsp_valid,
    output logic [DW-1:0]   p1_rsp_rdat,

    output logic            dram_we,
    output logic [DW/8-1:0] dram_we_byte,
    output logic            dram_rd,
    output logic [AW-1:0]   dram_addr,
    output logic [DW-1:0]   dram_wdat,
    input  logic [DW-1:0]   dram_dout
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_owner;
    logic                   w_winner;
    logic                   w_last_winner;
    logic [NUM_PORTS-1:0]   w_valid;

    logic                   w_own_valid;
    logic                   w_own_we;
    logic [DW/8-1:0]        w_own_be;
    logic [AW-1:0]          w_own_addr;
    logic [DW-1:0]          w_own_wdat;
    logic                   w_own_last;
    logic                   w_hs;
    logic                   w_rd_hs;
    logic                   w_grant;

    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DW-1:0]          r_rsp_rdat [NUM_PORTS];

    assign w_valid = {p1_req_valid, p0_req_valid};

    // Request fields of whichever port currently holds the grant.
    assign w_own_valid = r_owner ? p1_req_valid : p0_req_valid;
    assign w_own_we    = r_owner ? p1_req_we    : p0_req_we;
    assign w_own_be    = r_owner ? p1_req_be    : p0_req_be;
    assign w_own_addr  = r_owner ? p1_req_addr  : p0_req_addr;
    assign w_own_wdat  = r_owner ? p1_req_wdat  : p0_req_wdat;
    assign w_own_last  = r_owner ? p1_req_last  : p0_req_last;

    assign w_hs    = (r_state == BUSY) && w_own_valid;
    assign w_rd_hs = w_hs && !w_own_we;
    assign w_grant = (r_state == IDLE) && (|w_valid);

    dram_arb_pick u_pick (
        .valid       (w_valid),
        .last_winner (w_last_winner),
        .winner      (w_winner)
    );

`ifdef DRAM_ARB_RR_EN
    logic r_last_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= 1'b1;
        end else if (w_grant) begin
            r_last_winner <= w_winner;
        end
    end

    assign w_last_winner = r_last_winner;
`else
    assign w_last_winner = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_winner;
        end
    end

    // Next-state logic; an owner that goes quiet mid-sequence keeps the lock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_valid)             w_state_nxt = BUSY;
            BUSY:    if (w_hs && w_own_last)   w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // Output logic: ready from the grant, DRAM command only on a handshake.
    always_comb begin
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        dram_we      = 1'b0;
        dram_rd      = 1'b0;
        dram_we_byte = '0;
        dram_addr    = '0;
        dram_wdat    = '0;
        if (r_state == BUSY) begin
            p0_req_ready = ~r_owner;
            p1_req_ready = r_owner;
        end
        if (w_hs) begin
            dram_addr = w_own_addr;
            if (w_own_we) begin
                dram_we      = 1'b1;
                dram_we_byte = w_own_be;
                dram_wdat    = w_own_wdat;
            end else begin
                dram_rd      = 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rsp_valid[i] <= 1'b0;
                    r_rsp_rdat[i]  <= '0;
                end else begin
                    r_rsp_valid[i] <= w_rd_hs && (r_owner == 1'(i));
                    if (w_rd_hs && (r_owner == 1'(i))) begin
                        r_rsp_rdat[i] <= dram_dout;
                    end
                end
            end
        end
    endgenerate

    assign p0_rsp_valid = r_rsp_valid[0];
    assign p1_rsp_valid = r_rsp_valid[1];
    assign p0_rsp_rdat  = r_rsp_rdat[0];
    assign p1_rsp_rdat  = r_rsp_rdat[1];

endmodule : dram_arbiter

`default_nettype wire

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter AW, default 32, byte-address width on all ports.
REQ-002 Parameter DW, default 32, data width; DW/8 byte enables.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pN_req_valid  input  1  request valid, N in {0,1}; port 0 is core LSU, port 1 is DMA/debug.
REQ-006 pN_req_ready  output  1  request accepted this cycle when valid and ready are both high.
REQ-007 pN_req_we  input  1  1 = write, 0 = read.
REQ-008 pN_req_be  input  DW/8  write byte enables.
REQ-009 pN_req_addr  input  AW  byte address.
REQ-010 pN_req_wdat  input  DW  write data.
REQ-011 pN_req_last  input  1  final beat of a locked sequence; 1 for single accesses.
REQ-012 pN_rsp_valid  output  1  one-cycle pulse per accepted read.
REQ-013 pN_rsp_rdat  output  DW  read data, valid only while pN_rsp_valid is high.
REQ-014 dram_we, dram_we_byte[DW/8], dram_rd, dram_addr[AW], dram_wdat[DW]  outputs  memory command.
REQ-015 dram_dout  input  DW  memory read data, combinational from dram_rd/dram_addr.

Function
REQ-016 FSM states are IDLE and BUSY, plus a 1-bit owner register.
REQ-017 IDLE: all req_ready are 0; if any req_valid, select a winner (REQ-031), register it as owner, and go to BUSY.
REQ-018 BUSY: only owner's req_ready is 1; the other port's req_ready is 0.
REQ-019 On an owner handshake, drive dram_* combinationally from owner fields in the same cycle.
REQ-020 Read handshake drives dram_rd=1, dram_we=0, dram_we_byte=0.
REQ-021 Write handshake drives dram_we=1, dram_rd=0, dram_we_byte=req_be, dram_wdat=req_wdat.
REQ-022 When there is no handshake, all dram_* outputs are 0.
REQ-023 dram_addr is req_addr unchanged; addr[1:0] is passed through and not checked.
REQ-024 A read handshake registers dram_dout into owner's rsp_rdat, and owner's rsp_valid is 1 in the next cycle only; writes produce no response.
REQ-025 Latency: valid high from cycle T in IDLE, accepted in T+1, rsp_valid in T+2.
REQ-026 A handshake with last=1 returns to IDLE, giving one bubble cycle before the next grant; last=0 stays BUSY.
REQ-027 If the owner drops valid mid-sequence, remain BUSY and hold the grant; there is no timeout.
REQ-028 A write with be=0 still pulses dram_we with no bytes changed; a legal no-op.
REQ-029 rsp_valid of the finishing port may coincide with the other port's grant in IDLE; there is no conflict.

Reset
REQ-030 On rst_n low, immediately: state=IDLE, owner=0, last_winner=1, all req_ready/rsp_valid/dram_* =0, rsp_rdat=0; an in-flight response is discarded, with no pulse after release.

Configuration
REQ-031 With DRAM_ARB_RR_EN defined, simultaneous requests in IDLE go to the port not equal to last_winner, and last_winner updates at each grant. Without it, port 0 always wins and the last_winner register is not built.

Structure
REQ-032 Package dram_arb_pkg holds the state enum (IDLE, BUSY), NUM_PORTS=2, and the default AW/DW constants.
REQ-033 Winner selection lives in sub-module dram_arb_pick (inputs valid[1:0], last_winner; output winner); it is purely combinational.

Verification
REQ-034 p0 reads addr 0x10 with memory word 0xCAFEF00D -> p0_rsp_valid pulses 2 cycles after valid rises, with rdat=0xCAFEF00D.
REQ-035 p1 writes 0x11223344 be=4'b0101 to 0x20 over 0xFFFFFFFF -> a p0 read returns 0xFF22FF44.
REQ-036 Both valid continuously, singles, RR build -> grants alternate 0,1,0,1; non-RR build -> p0 only, p1 starves.
REQ-037 p1 runs a 3-beat locked sequence (last on beat 3) while p0 is valid; p1 drops valid for 2 cycles mid-sequence -> p0_req_ready stays 0 until after p1's last beat.
REQ-038 rst_n asserted the cycle after a read handshake -> no rsp_valid ever, dram_rd=0 immediately, IDLE after release.
